// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU conversion/rounding units: IEEE-754 single
// precision field widths, exponent bias, rounding-mode encodings and small
// helpers common to every unit that rounds a mantissa.
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int FLT_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;

  // Rounding-mode encodings shared by all FPU units
  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  // Biased exponent of 2^31, the largest magnitude a 32-bit integer reaches
  localparam logic [EXP_W-1:0] EXP_INT_TOP = 8'(FLT_BIAS + 31);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } flt32_t;

  // Round-up decision for a mantissa whose discarded bits are summarised by
  // guard and sticky. Nearest-even rounds a tie only when the kept lsb is odd.
  function automatic logic round_up(input logic rm, input logic lsb,
                                    input logic guard, input logic sticky);
    logic up;
    if (rm == RM_RNE) begin
      up = guard & (sticky | lsb);
    end else begin
      up = 1'b0;
    end
    return up;
  endfunction

endpackage

// File: rtl/itof_pipe_lzc32.sv
// ---------------------------------------------------------------------------
// lzc32
// Combinational 32-bit leading-zero counter, reusable by normalisation paths.
//   a  : operand
//   lz : number of leading zeros of a, 32 when a is zero
// ---------------------------------------------------------------------------
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  lz
);

  logic [5:0] lz_s;

  // Scan upward so the highest set bit is the last one to update the count
  always_comb begin
    lz_s = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) begin
        lz_s = 6'(31 - i);
      end else begin
        lz_s = lz_s;
      end
    end
  end

  assign lz = lz_s;

endmodule

// File: rtl/itof_pipe.sv
// ---------------------------------------------------------------------------
// itof_pipe
// Three-stage signed 32-bit integer to IEEE-754 single converter with
// valid/ready handshakes on both sides and per-operation rounding mode.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for x, rm, in_tag
//   x                   : signed integer operand
//   rm                  : 0 = nearest-even, 1 = toward zero
//   in_tag              : opaque tag carried alongside the operation
//   out_valid/out_ready : output handshake for y, out_tag
//   y                   : float result {sign, exp, frac}
//   out_tag             : tag of the result
// Stages: S1 sign/magnitude, S2 normalise, S3 round and pack (output regs).
// ---------------------------------------------------------------------------
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic             rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
);

  // Stage registers
  logic             s1_valid_r, s1_sign_r, s1_rm_r;
  logic [31:0]      s1_mag_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             s2_valid_r, s2_sign_r, s2_rm_r;
  logic [31:0]      s2_norm_r;
  logic [5:0]       s2_lz_r;
  logic [TAG_W-1:0] s2_tag_r;

  logic             s3_valid_r;
  logic [31:0]      s3_y_r;
  logic [TAG_W-1:0] s3_tag_r;

  // Combinational signals
  logic              adv1_s, adv2_s, adv3_s;
  logic [31:0]       mag_s;
  logic [5:0]        lz_s;
  logic [31:0]       norm_s;
  logic [23:0]       frac24_s;
  logic              guard_s, sticky_s, inc_s;
  logic [24:0]       sum25_s;
  logic [EXP_W-1:0]  exp_base_s, exp_s;
  logic [FRAC_W-1:0] frac_s;
  flt32_t            y_s;

  // A stage advances when empty or when the stage after it advances, so a
  // consumer accept propagates back to in_ready in the same cycle.
  assign adv3_s   = !s3_valid_r || out_ready;
  assign adv2_s   = !s2_valid_r || adv3_s;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;

  // Two's-complement magnitude; 0x80000000 negates to itself, which read as
  // unsigned is exactly 2^31.
  assign mag_s = x[31] ? (~x + 32'd1) : x;

  lzc32 u_lzc (
    .a  (s1_mag_r),
    .lz (lz_s)
  );

  assign norm_s = s1_mag_r << lz_s;

  // Round and pack from the normalised mantissa held in S2
  always_comb begin
    frac24_s   = s2_norm_r[31:8];
    guard_s    = s2_norm_r[7];
    sticky_s   = |s2_norm_r[6:0];
    inc_s      = round_up(s2_rm_r, frac24_s[0], guard_s, sticky_s);
    sum25_s    = {1'b0, frac24_s} + {24'd0, inc_s};
    exp_base_s = EXP_INT_TOP - {2'b00, s2_lz_r};
    // Mantissa overflow leaves 1.000..0 one binade up
    if (sum25_s[24]) begin
      exp_s  = exp_base_s + 8'd1;
      frac_s = 23'd0;
    end else begin
      exp_s  = exp_base_s;
      frac_s = sum25_s[22:0];
    end
    // A zero operand never yields -0 and has no implicit one to pack
    if (!s2_norm_r[31]) begin
      y_s = 32'd0;
    end else begin
      y_s = '{sign: s2_sign_r, exp: exp_s, frac: frac_s};
    end
  end

  // Pipeline registers; reset drops every in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
      s3_y_r     <= 32'd0;
      s3_tag_r   <= '0;
    end else begin
      if (adv1_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_sign_r <= x[31];
          s1_mag_r  <= mag_s;
          s1_rm_r   <= rm;
          s1_tag_r  <= in_tag;
        end
      end
      if (adv2_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_sign_r <= s1_sign_r;
          s2_norm_r <= norm_s;
          s2_lz_r   <= lz_s;
          s2_rm_r   <= s1_rm_r;
          s2_tag_r  <= s1_tag_r;
        end
      end
      // Output registers only change when a new result moves in, so y and
      // out_tag stay frozen under backpressure.
      if (adv3_s) begin
        s3_valid_r <= s2_valid_r;
        if (s2_valid_r) begin
          s3_y_r   <= y_s;
          s3_tag_r <= s2_tag_r;
        end
      end
    end
  end

  assign out_valid = s3_valid_r;
  assign y         = s3_y_r;
  assign out_tag   = s3_tag_r;

endmodule

// File: tb/tb_itof_pipe.sv
// ---------------------------------------------------------------------------
// tb_itof_pipe
// Directed and random-handshake tests for itof_pipe. Inputs are driven on
// the falling edge; outputs and handshakes are sampled 1 time unit later,
// before the rising edge on which the transfers happen.
// ---------------------------------------------------------------------------
module tb_itof_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x;
  logic             rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  // Operation list for run_ops and the results it collects
  logic [31:0]      op_x[$];
  logic             op_rm[$];
  logic [TAG_W-1:0] op_tag[$];
  logic [31:0]      got_y[$];
  logic [TAG_W-1:0] got_tag[$];
  int               got_lat[$];

  always #5 clk = ~clk;

  itof_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .rm        (rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag)
  );

  // Reference: locate the msb, shift down and round on the exact remainder
  function automatic logic [31:0] ref_itof(input logic [31:0] xv, input logic rmv);
    logic s;
    logic [31:0] m;
    int p, e, sh;
    longint unsigned q, rem, half;
    s = xv[31];
    m = s ? (32'd0 - xv) : xv;
    if (m == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = {32'd0, m} << (23 - p);
    end else begin
      sh   = p - 23;
      q    = {32'd0, m} >> sh;
      rem  = {32'd0, m} & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (!rmv && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
    end
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] xv, input logic rmv,
                       input logic [TAG_W-1:0] tv, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    x         = xv;
    rm        = rmv;
    in_tag    = tv;
    out_ready = ordy;
    #1;
  endtask

  // Streams op_* back to back with out_ready high and records each result
  // and its latency in cycles from input transfer.
  task automatic run_ops();
    int acc_q[$];
    int idx = 0;
    got_y.delete(); got_tag.delete(); got_lat.delete();
    for (int cyc = 0; cyc < 40 && got_y.size() < op_x.size(); cyc++) begin
      if (idx < op_x.size()) drive(1'b1, op_x[idx], op_rm[idx], op_tag[idx], 1'b1);
      else drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
      if (out_valid && out_ready && acc_q.size() > 0) begin
        got_y.push_back(y);
        got_tag.push_back(out_tag);
        got_lat.push_back(cyc - acc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        idx++;
      end
    end
    in_valid = 1'b0;
    op_x.delete(); op_rm.delete(); op_tag.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || y !== 32'd0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b y=%h out_tag=%h, need 0/00000000/0", out_valid, y, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, need 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] xs[5]  = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] exp[5] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h4F000000, 32'hCF000000};
    for (int i = 0; i < 5; i++) begin
      op_x.push_back(xs[i]); op_rm.push_back(1'b0); op_tag.push_back(TAG_W'(i + 3));
    end
    run_ops();
    checks++;
    if (got_y.size() !== 5) begin
      errors++;
      $display("FAIL basic_count: got %0d results, need 5", got_y.size());
    end
    for (int i = 0; i < 5 && i < got_y.size(); i++) begin
      checks++;
      if (got_y[i] !== exp[i] || got_tag[i] !== TAG_W'(i + 3) || got_lat[i] !== 3) begin
        errors++;
        $display("FAIL basic_%0d: y=%h tag=%0d lat=%0d, need y=%h tag=%0d lat=3",
                 i, got_y[i], got_tag[i], got_lat[i], exp[i], i + 3);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] xs[6]  = '{32'd16777217, 32'd16777219, 32'd16777219, 32'hFEFFFFFF,
                            32'h01FFFFFF, 32'h01FFFFFF};
    logic        rms[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp[6] = '{32'h4B800000, 32'h4B800002, 32'h4B800001, 32'hCB800000,
                            32'h4C000000, 32'h4BFFFFFF};
    for (int i = 0; i < 6; i++) begin
      op_x.push_back(xs[i]); op_rm.push_back(rms[i]); op_tag.push_back(TAG_W'(20 + i));
    end
    run_ops();
    checks++;
    if (got_y.size() !== 6) begin
      errors++;
      $display("FAIL round_count: got %0d results, need 6", got_y.size());
    end
    for (int i = 0; i < 6 && i < got_y.size(); i++) begin
      checks++;
      if (got_y[i] !== exp[i] || got_tag[i] !== TAG_W'(20 + i)) begin
        errors++;
        $display("FAIL round_%0d: y=%h tag=%0d, need y=%h tag=%0d", i, got_y[i], got_tag[i], exp[i], 20 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int nout = 0;
    logic [31:0] e1 = ref_itof(32'd100, 1'b0);
    // Stall the consumer while offering tags 1..5
    for (int c = 0; c < 8; c++) begin
      if (acc < 5) drive(1'b1, 32'(100 * (acc + 1)), 1'b0, TAG_W'(acc + 1), 1'b0);
      else drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
      if (in_valid && in_ready) acc++;
      if (c >= 4) begin
        checks++;
        if (y !== e1 || out_tag !== TAG_W'(1) || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_frozen_c%0d: out_valid=%b y=%h tag=%0d, need 1/%h/1", c, out_valid, y, out_tag, e1);
        end
      end
    end
    checks++;
    if (acc !== 3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepted: accepted=%0d in_ready=%b, need 3/0", acc, in_ready);
    end
    // Release: full pipe plus accept must open in_ready in the same cycle
    for (int c = 0; c < 30 && nout < 5; c++) begin
      if (acc < 5) drive(1'b1, 32'(100 * (acc + 1)), 1'b0, TAG_W'(acc + 1), 1'b1);
      else drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_passthru_ready: in_ready=%b, need 1", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        nout++;
        checks++;
        if (out_tag !== TAG_W'(nout) || y !== ref_itof(32'(100 * nout), 1'b0)) begin
          errors++;
          $display("FAIL bp_order_%0d: tag=%0d y=%h, need tag=%0d y=%h", nout, out_tag, y, nout,
                   ref_itof(32'(100 * nout), 1'b0));
        end
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    checks++;
    if (nout !== 5) begin
      errors++;
      $display("FAIL bp_drain: got %0d results, need 5", nout);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(7 + i), 1'b0, TAG_W'(9), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'd0 || out_tag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b y=%h tag=%0d in_ready=%b, need 0/00000000/0/1",
               out_valid, y, out_tag, in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 32'd0, 1'b0, '0, 1'b1);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL rst_stale: %0d stale results seen, need 0", stale);
    end
    op_x.push_back(32'd5); op_rm.push_back(1'b0); op_tag.push_back(TAG_W'(17));
    run_ops();
    checks++;
    if (got_y.size() !== 1 || got_y[0] !== 32'h40A00000 || got_tag[0] !== TAG_W'(17)) begin
      errors++;
      $display("FAIL rst_recover: count=%0d y=%h, need 1 result y=40a00000 tag=17",
               got_y.size(), (got_y.size() > 0) ? got_y[0] : 32'd0);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [31:0]      exp_y[$];
    logic [TAG_W-1:0] exp_t[$];
    logic [31:0]      xv;
    logic [31:0]      ev;
    logic [TAG_W-1:0] et;
    int sent = 0;
    int recv = 0;
    for (int c = 0; c < 60000 && recv < N; c++) begin
      case ($urandom_range(0, 3))
        0: xv = $urandom;
        1: xv = 32'($urandom_range(0, 300)) - 32'd150;
        2: xv = 32'h01000000 + 32'($urandom_range(0, 7));
        default: xv = $urandom >> $urandom_range(0, 31);
      endcase
      drive((sent < N) ? 1'($urandom_range(0, 1)) : 1'b0, xv, 1'($urandom_range(0, 1)),
            TAG_W'(sent), 1'($urandom_range(0, 1)));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_y.size() == 0) begin
          errors++;
          $display("FAIL rand_stale: unexpected y=%h tag=%0d", y, out_tag);
        end else begin
          ev = exp_y.pop_front();
          et = exp_t.pop_front();
          recv++;
          if (y !== ev || out_tag !== et) begin
            errors++;
            $display("FAIL rand_%0d: y=%h tag=%0d, need y=%h tag=%0d", recv, y, out_tag, ev, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_y.push_back(ref_itof(x, rm));
        exp_t.push_back(in_tag);
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== N) begin
      errors++;
      $display("FAIL rand_timeout: received %0d results, need %0d", recv, N);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    x         = 32'd0;
    rm        = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
